imm_extend_stage: RTL and testbench

IMM_EXTEND_STAGE -- requirements
Module: imm_extend_stage

---
 rtl/imm_pkg.sv | 30 +++
 rtl/imm_decode.sv | 58 +++++
 rtl/imm_extend_stage.sv | 138 +++++++++++++
 tb/tb_imm_extend_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// ----------------------------------------------------------------------------
// imm_pkg
// Shared types and constants for the immediate-extend stage.
//   imm_src_e   : immediate format select (3 bits), IMM_I .. IMM_ILL
//   buf_state_e : occupancy of the two-entry skid buffer
//   XLEN_32/64  : the two legal immediate output widths
// ----------------------------------------------------------------------------
package imm_pkg;

    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_J     = 3'b011,
        IMM_U     = 3'b100,
        IMM_Z     = 3'b101,
        IMM_SHAMT = 3'b110,
        IMM_ILL   = 3'b111
    } imm_src_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b10
    } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// ----------------------------------------------------------------------------
// imm_decode
// Combinational immediate extraction and extension.
//   instr   [31:0]     : raw instruction word
//   imm_src [2:0]      : format select (imm_src_e encoding)
//   imm     [XLEN-1:0] : extended immediate
//   err                : select 111 used while illegal checking is enabled
// Optional feature: IMM_EXTEND_ILLEGAL_CHECK_EN. When defined, select 111
// yields imm=0/err=1; otherwise select 111 decodes as the I format, err=0.
// ----------------------------------------------------------------------------
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = XLEN_32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // Opcode bits never contribute to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // Every format is first built as a 32-bit value; Z and SHAMT keep bit 31
    // clear so the common sign extension to XLEN leaves them zero-extended.
    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        err   = 1'b0;
        case (imm_src_e'(imm_src))
            IMM_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0};
            IMM_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                                instr[20], instr[30:21], 1'b0};
            IMM_U:     imm32 = {instr[31:12], 12'd0};
            IMM_Z:     imm32 = {27'd0, instr[19:15]};
            // RV32 shift amounts are 5 bits, so bit 25 is ignored there.
            IMM_SHAMT: imm32 = {26'd0, (XLEN == XLEN_32) ? 1'b0 : instr[25],
                                instr[24:20]};
            IMM_ILL: begin
`ifdef IMM_EXTEND_ILLEGAL_CHECK_EN
                imm32 = '0;
                err   = 1'b1;
`else
                imm32 = {{20{instr[31]}}, instr[31:20]};
`endif
            end
        endcase
        // Size cast of a signed value sign-extends.
        imm = XLEN'(imm32);
    end

endmodule

// File: rtl/imm_extend_stage.sv
// ----------------------------------------------------------------------------
// imm_extend_stage
// Valid/ready pipeline stage that extends the immediate of each instruction
// and carries an opaque tag alongside it, buffered by a two-entry skid buffer
// so in_ready never depends combinationally on out_ready.
// Ports:
//   clk, rst_n                 : rising-edge clock, synchronous active-low reset
//   in_valid / in_ready        : input handshake
//   in_instr [31:0]            : raw instruction word
//   in_imm_src [2:0]           : immediate format select
//   in_tag [TAG_W-1:0]         : sideband tag
//   out_valid / out_ready      : output handshake
//   out_imm [XLEN-1:0]         : extended immediate
//   out_tag [TAG_W-1:0]        : tag of the presented result
//   out_err                    : illegal format select was used
// Optional feature: IMM_EXTEND_ILLEGAL_CHECK_EN (see imm_decode).
// ----------------------------------------------------------------------------
module imm_extend_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = XLEN_32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    // ---- stage p0: combinational decode of the offered instruction ----
    logic [XLEN-1:0] dec_imm_p0;
    logic            dec_err_p0;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr   (in_instr),
        .imm_src (in_imm_src),
        .imm     (dec_imm_p0),
        .err     (dec_err_p0)
    );

    // ---- stage p1: main + skid registers and their occupancy FSM ----
    buf_state_e state_q, state_nxt;

    logic             push, pop;
    logic             load_main, load_skid, skid_to_main;
    logic [XLEN-1:0]  main_imm_p1, skid_imm_p1;
    logic [TAG_W-1:0] main_tag_p1, skid_tag_p1;
    logic             main_err_p1, skid_err_p1;

    assign in_ready  = (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_nxt    = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    state_nxt = BUF_ONE;
                    load_main = 1'b1;
                end
            end
            BUF_ONE: begin
                case ({push, pop})
                    2'b10: begin
                        state_nxt = BUF_FULL;
                        load_skid = 1'b1;
                    end
                    2'b01: state_nxt = BUF_EMPTY;
                    // Simultaneous push and pop replaces main in place.
                    2'b11: load_main = 1'b1;
                    default: ;
                endcase
            end
            BUF_FULL: begin
                // in_ready is low here, so only a pop can occur.
                if (pop) begin
                    state_nxt    = BUF_ONE;
                    skid_to_main = 1'b1;
                end
            end
            default: state_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Main register is cleared on reset so the outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_imm_p1 <= '0;
            main_tag_p1 <= '0;
            main_err_p1 <= 1'b0;
        end else if (load_main) begin
            main_imm_p1 <= dec_imm_p0;
            main_tag_p1 <= in_tag;
            main_err_p1 <= dec_err_p0;
        end else if (skid_to_main) begin
            main_imm_p1 <= skid_imm_p1;
            main_tag_p1 <= skid_tag_p1;
            main_err_p1 <= skid_err_p1;
        end
    end

    // Skid contents are only ever read in FULL, so they need no reset.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_imm_p1 <= dec_imm_p0;
            skid_tag_p1 <= in_tag;
            skid_err_p1 <= dec_err_p0;
        end
    end

    assign out_imm = main_imm_p1;
    assign out_tag = main_tag_p1;
    assign out_err = main_err_p1;

endmodule

// File: tb/tb_imm_extend_stage.sv
// ----------------------------------------------------------------------------
// tb_imm_extend_stage
// Directed bench for imm_extend_stage with one XLEN=32 and one XLEN=64
// instance sharing clock and reset. Expected values are hand-derived.
// ----------------------------------------------------------------------------
module tb_imm_extend_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [31:0] a_in_instr, a_out_imm;
    logic [2:0]  a_in_imm_src;
    logic [4:0]  a_in_tag, a_out_tag;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [31:0] b_in_instr;
    logic [63:0] b_out_imm;
    logic [2:0]  b_in_imm_src;
    logic [4:0]  b_in_tag, b_out_tag;

    imm_extend_stage #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_instr   (a_in_instr),
        .in_imm_src (a_in_imm_src),
        .in_tag     (a_in_tag),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_imm    (a_out_imm),
        .out_tag    (a_out_tag),
        .out_err    (a_out_err)
    );

    imm_extend_stage #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_instr   (b_in_instr),
        .in_imm_src (b_in_imm_src),
        .in_tag     (b_in_tag),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_imm    (b_out_imm),
        .out_tag    (b_out_tag),
        .out_err    (b_out_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction to an empty dut32, check it one cycle later, drain.
    task automatic one32(input string name, input logic [31:0] instr,
                         input logic [2:0] src, input logic [4:0] tag,
                         input logic [31:0] exp_imm, input logic exp_err);
        a_in_valid   = 1'b1;
        a_in_instr   = instr;
        a_in_imm_src = src;
        a_in_tag     = tag;
        a_out_ready  = 1'b0;
        tick();
        a_in_valid = 1'b0;
        check_eq({name, "_vld"}, 64'(a_out_valid), 64'd1);
        check_eq({name, "_imm"}, 64'(a_out_imm), 64'(exp_imm));
        check_eq({name, "_tag"}, 64'(a_out_tag), 64'(tag));
        check_eq({name, "_err"}, 64'(a_out_err), 64'(exp_err));
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check_eq({name, "_drain"}, 64'(a_out_valid), 64'd0);
    endtask

    task automatic one64(input string name, input logic [31:0] instr,
                         input logic [2:0] src, input logic [4:0] tag,
                         input logic [63:0] exp_imm);
        b_in_valid   = 1'b1;
        b_in_instr   = instr;
        b_in_imm_src = src;
        b_in_tag     = tag;
        b_out_ready  = 1'b0;
        tick();
        b_in_valid = 1'b0;
        check_eq({name, "_vld"}, 64'(b_out_valid), 64'd1);
        check_eq({name, "_imm"}, b_out_imm, exp_imm);
        check_eq({name, "_tag"}, 64'(b_out_tag), 64'(tag));
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        check_eq({name, "_drain"}, 64'(b_out_valid), 64'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        a_in_valid   = 1'b0;
        a_in_instr   = '0;
        a_in_imm_src = '0;
        a_in_tag     = '0;
        a_out_ready  = 1'b0;
        b_in_valid   = 1'b0;
        b_in_instr   = '0;
        b_in_imm_src = '0;
        b_in_tag     = '0;
        b_out_ready  = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst_vld", 64'(a_out_valid), 64'd0);
        check_eq("rst_imm", 64'(a_out_imm), 64'd0);
        check_eq("rst_tag", 64'(a_out_tag), 64'd0);
        check_eq("rst_err", 64'(a_out_err), 64'd0);
        check_eq("rst_rdy", 64'(a_in_ready), 64'd1);
        check_eq("rst_imm64", b_out_imm, 64'd0);
        rst_n = 1'b1;
        tick();

        // Formats, XLEN=32
        one32("i32", 32'hFFF00093, 3'd0, 5'd1, 32'hFFFFFFFF, 1'b0);
        one32("s32", 32'hFE20AE23, 3'd1, 5'd2, 32'hFFFFFFFC, 1'b0);
        one32("b32", 32'hFE000CE3, 3'd2, 5'd3, 32'hFFFFFFF8, 1'b0);
        one32("j32", 32'hFFDFF06F, 3'd3, 5'd4, 32'hFFFFFFFC, 1'b0);
        one32("shamt32", 32'h03F09093, 3'd6, 5'd5, 32'd31, 1'b0);

        // Formats, XLEN=64
        one64("u64", 32'h80000037, 3'd4, 5'd6, 64'hFFFFFFFF80000000);
        one64("shamt64", 32'h03F09093, 3'd6, 5'd7, 64'd63);
        one64("z64", 32'h000F8000, 3'd5, 5'd8, 64'h1F);

        // Illegal select, then a legal entry must not inherit the error flag
`ifdef IMM_EXTEND_ILLEGAL_CHECK_EN
        one32("ill", 32'hFFF00093, 3'd7, 5'd9, 32'd0, 1'b1);
`else
        one32("ill", 32'hFFF00093, 3'd7, 5'd9, 32'hFFFFFFFF, 1'b0);
`endif
        one32("post_ill", 32'h00500093, 3'd0, 5'd10, 32'd5, 1'b0);

        // Backpressure: three offers, two accepted, order preserved
        a_out_ready  = 1'b0;
        a_in_valid   = 1'b1;
        a_in_imm_src = 3'd0;
        a_in_instr   = 32'h00100093;
        a_in_tag     = 5'd1;
        tick();
        check_eq("bp_one_rdy", 64'(a_in_ready), 64'd1);
        check_eq("bp_one_tag", 64'(a_out_tag), 64'd1);
        a_in_instr = 32'h00200093;
        a_in_tag   = 5'd2;
        tick();
        check_eq("bp_full_rdy", 64'(a_in_ready), 64'd0);
        check_eq("bp_full_imm", 64'(a_out_imm), 64'd1);
        a_in_instr = 32'h00300093;
        a_in_tag   = 5'd3;
        tick();
        check_eq("bp_hold_rdy", 64'(a_in_ready), 64'd0);
        check_eq("bp_hold_imm", 64'(a_out_imm), 64'd1);
        check_eq("bp_hold_tag", 64'(a_out_tag), 64'd1);
        a_out_ready = 1'b1;
        tick();
        check_eq("bp_r2_tag", 64'(a_out_tag), 64'd2);
        check_eq("bp_r2_imm", 64'(a_out_imm), 64'd2);
        check_eq("bp_r2_rdy", 64'(a_in_ready), 64'd1);
        tick();
        a_in_valid = 1'b0;
        check_eq("bp_r3_vld", 64'(a_out_valid), 64'd1);
        check_eq("bp_r3_tag", 64'(a_out_tag), 64'd3);
        check_eq("bp_r3_imm", 64'(a_out_imm), 64'd3);
        tick();
        check_eq("bp_end_vld", 64'(a_out_valid), 64'd0);

        // Throughput: one result per cycle, buffer stays at one entry
        a_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_in_valid = 1'b1;
            a_in_instr = {12'(i + 16), 20'h00093};
            a_in_tag   = 5'(i + 8);
            tick();
            check_eq($sformatf("tp%0d_vld", i), 64'(a_out_valid), 64'd1);
            check_eq($sformatf("tp%0d_tag", i), 64'(a_out_tag), 64'(i + 8));
            check_eq($sformatf("tp%0d_imm", i), 64'(a_out_imm), 64'(i + 16));
            check_eq($sformatf("tp%0d_rdy", i), 64'(a_in_ready), 64'd1);
        end
        a_in_valid = 1'b0;
        tick();
        check_eq("tp_end_vld", 64'(a_out_valid), 64'd0);

        // Reset while FULL discards both entries
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_instr  = 32'h01400093;
        a_in_tag    = 5'd20;
        tick();
        a_in_instr = 32'h01500093;
        a_in_tag   = 5'd21;
        tick();
        check_eq("rf_full_rdy", 64'(a_in_ready), 64'd0);
        a_in_instr  = 32'h01600093;
        a_in_tag    = 5'd22;
        a_out_ready = 1'b1;
        rst_n       = 1'b0;
        tick();
        rst_n      = 1'b1;
        a_in_valid = 1'b0;
        check_eq("rf_vld", 64'(a_out_valid), 64'd0);
        check_eq("rf_rdy", 64'(a_in_ready), 64'd1);
        check_eq("rf_imm", 64'(a_out_imm), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("rf_stale%0d", i), 64'(a_out_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
